// File: rtl/iterative_alu.sv
// iterative_alu: RV32I execute-stage ALU. Logic/arithmetic/compare ops finish
// in one cycle; shifts walk one bit per cycle through a small work register.
// Valid/ready on both sides; one operation in flight at a time.
module iterative_alu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            invert,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            branch_cond
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           op_q;
  logic                 invert_q;
  logic [XLEN-1:0]      work;
  logic [SHAMT_W-1:0]   cnt;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      quick_res;
  logic [XLEN-1:0]      shift_next;

  // True for the three shift opcodes.
  function automatic logic is_shift(input logic [3:0] f_op);
    return (f_op == OP_SLL) || (f_op == OP_SRL) || (f_op == OP_SRA);
  endfunction

  // Single-cycle result. Shifts only reach this path with a zero shift
  // amount, in which case the operand passes through unchanged.
  function automatic logic [XLEN-1:0] alu_op(input logic [3:0]      f_op,
                                             input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    case (f_op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_XOR:  r = x ^ y;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (x < y)};
      OP_SLL:  r = x;
      OP_SRL:  r = x;
      OP_SRA:  r = x;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One bit-step of the iterative shifter.
  function automatic logic [XLEN-1:0] shift_step(input logic [3:0]      f_op,
                                                 input logic [XLEN-1:0] w);
    logic [XLEN-1:0] r;
    case (f_op)
      OP_SLL:  r = {w[XLEN-2:0], 1'b0};
      OP_SRL:  r = {1'b0, w[XLEN-1:1]};
      OP_SRA:  r = {w[XLEN-1], w[XLEN-1:1]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign shamt      = b[SHAMT_W-1:0];
  assign quick_res  = alu_op(op, a, b);
  assign shift_next = shift_step(op_q, work);
  assign in_ready   = (state == IDLE);

  // Control FSM plus the registered result, flags and shifter datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= 4'd0;
      invert_q    <= 1'b0;
      work        <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      branch_cond <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            invert_q <= invert;
            if (is_shift(op) && (shamt != '0)) begin
              work  <= a;
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              result      <= quick_res;
              zero        <= (quick_res == '0);
              branch_cond <= (quick_res == '0) ^ invert;
              out_valid   <= 1'b1;
              state       <= DONE;
            end
          end
        end
        SHIFT: begin
          // The last step goes straight into result so the shift finishes
          // on the same edge that the counter expires.
          if (cnt == SHAMT_W'(1)) begin
            result      <= shift_next;
            zero        <= (shift_next == '0);
            branch_cond <= (shift_next == '0) ^ invert_q;
            out_valid   <= 1'b1;
            cnt         <= '0;
            state       <= DONE;
          end else begin
            work <= shift_next;
            cnt  <= cnt - SHAMT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu: the driver pushes hand-computed
// expectations on accept, an independent monitor checks them on output.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        invert;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        branch_cond;

  iterative_alu #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .invert(invert), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .branch_cond(branch_cond)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        bc;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: busy-state in_ready, held output values, latency, pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() != 0 && !out_valid) check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          check({sb[0].name, "_result"}, result, sb[0].res);
          check({sb[0].name, "_zero"}, {31'd0, zero}, {31'd0, sb[0].z});
          check({sb[0].name, "_bc"}, {31'd0, branch_cond}, {31'd0, sb[0].bc});
          check({sb[0].name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
          if (!prev_valid) check({sb[0].name, "_latency"}, cyc - sb[0].acc + 1, sb[0].lat);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
    prev_valid = out_valid;
  end

  // Present an operation, wait (bounded) for acceptance, then log expectation.
  task automatic do_op(input string name, input logic [3:0] o, input logic inv,
                       input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] er, input logic ez, input logic ebc, input int elat);
    exp_t e;
    bit   ok = 1'b0;
    op = o; invert = inv; a = xa; b = xb; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check({name, "_accept_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e.res = er; e.z = ez; e.bc = ebc; e.lat = elat; e.acc = cyc; e.name = name;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check({name, "_drain_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 4'd0; invert = 1'b0;
    a = 32'd0; b = 32'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_bc", {31'd0, branch_cond}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    do_op("add_wrap",  4'd2,  1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1);
    do_op("sub_eq",    4'd3,  1'b0, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1, 1);
    do_op("sub_eq_inv",4'd3,  1'b1, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1);
    do_op("sub_under", 4'd3,  1'b0, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    do_op("slt",       4'd6,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    do_op("sltu",      4'd7,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 1);
    do_op("and",       4'd0,  1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'hF0F0_0000, 1'b0, 1'b0, 1);
    do_op("or",        4'd1,  1'b1, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'hFFFF_F0F0, 1'b0, 1'b1, 1);
    do_op("sra4",      4'd9,  1'b0, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1'b0, 5);
    do_op("srl4",      4'd8,  1'b0, 32'h8000_0010, 32'd4, 32'h0800_0001, 1'b0, 1'b0, 5);
    do_op("sll31",     4'd5,  1'b0, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
    do_op("sll_sh0",   4'd5,  1'b0, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, 1'b0, 1);
    do_op("srl_sh1",   4'd8,  1'b0, 32'h0000_0003, 32'd1, 32'h0000_0001, 1'b0, 1'b0, 2);
    do_op("reserved",  4'd12, 1'b1, 32'h1234_5678, 32'h0000_0001, 32'd0, 1'b1, 1'b0, 1);
    drain("basic");

    // Backpressure: hold out_ready low for 3 DONE cycles; a second request
    // waits on in_valid and is only taken after the handshake.
    out_ready = 1'b0;
    do_op("xor_bp", 4'd4, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 1'b0, 1);
    fork
      do_op("add_after_bp", 4'd2, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);
      begin
        repeat (2) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain("bp");

    // Reset in the middle of a long shift discards it.
    do_op("sll20_rst", 4'd5, 1'b0, 32'd1, 32'd20, 32'h0010_0000, 1'b0, 1'b0, 21);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    do_op("add_post_rst", 4'd2, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
